interpolation_feeder: RTL and testbench



---
 rtl/fme_pkg.sv | 18 +
 rtl/feeder_row_mem.sv | 37 +++
 rtl/interpolation_feeder.sv | 176 +++++++++++++++++
 tb/tb_interpolation_feeder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fme_pkg.sv
// Shared definitions for the interpolation feeder.
// Holds the default block geometry (sample width, lanes per row, rows per
// block) and the encoding of the feeder control states.
package fme_pkg;

    localparam int DATAWIDTH = 8;
    localparam int LANES     = 16;
    localparam int ROWS      = 12;
    localparam int ROW_W     = $clog2(ROWS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/feeder_row_mem.sv
// Row storage for one interpolation block.
// ROWS x (LANES*DATAWIDTH) register file, one synchronous write port and one
// asynchronous read port. Contents are not reset: every row is rewritten
// during LOAD before it is read during STREAM.
//   clock      : write clock, rising edge
//   i_wr_en    : write strobe
//   i_wr_addr  : row written when i_wr_en is high
//   i_wr_data  : packed row to write
//   i_rd_addr  : row to read
//   o_rd_data  : packed row at i_rd_addr
module feeder_row_mem
    import fme_pkg::*;
#(
    parameter int DATAWIDTH = fme_pkg::DATAWIDTH,
    parameter int LANES     = fme_pkg::LANES,
    parameter int ROWS      = fme_pkg::ROWS,
    parameter int ROW_W     = $clog2(ROWS)
) (
    input  logic                       clock,
    input  logic                       i_wr_en,
    input  logic [ROW_W-1:0]           i_wr_addr,
    input  logic [LANES*DATAWIDTH-1:0] i_wr_data,
    input  logic [ROW_W-1:0]           i_rd_addr,
    output logic [LANES*DATAWIDTH-1:0] o_rd_data
);

    logic [LANES*DATAWIDTH-1:0] r_mem [ROWS];

    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/interpolation_feeder.sv
// Interpolation feeder: loads one block of ROWS packed rows through a
// valid/ready port, then streams the rows back-to-back onto 16 lane outputs
// with a qualifying enable for the interpolation stage.
//   clock, reset          : rising-edge clock, async active-low reset
//   start                 : begin a block (honoured in IDLE only)
//   abort                 : cancel the current block, back to IDLE
//   in_valid/in_data      : row input; in_ready high while loading
//   enable_int            : out_0..out_15 and row_idx carry a valid row
//   out_0..out_15         : lane samples of the presented row
//   row_idx               : index of the presented row
//   busy                  : any state other than IDLE
//   block_done            : one-cycle pulse after the last row
//
// state     | meaning
// ST_IDLE   | waiting for start
// ST_LOAD   | accepting rows into the row memory
// ST_STREAM | presenting rows 0..ROWS-1 one per cycle
// ST_DONE   | block_done pulse, then back to IDLE
module interpolation_feeder
    import fme_pkg::*;
#(
    parameter int DATAWIDTH = fme_pkg::DATAWIDTH,
    parameter int LANES     = fme_pkg::LANES,
    parameter int ROWS      = fme_pkg::ROWS,
    parameter int ROW_W     = $clog2(ROWS)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       in_valid,
    input  logic [LANES*DATAWIDTH-1:0] in_data,
    output logic                       in_ready,
    output logic                       enable_int,
    output logic [DATAWIDTH-1:0]       out_0,
    output logic [DATAWIDTH-1:0]       out_1,
    output logic [DATAWIDTH-1:0]       out_2,
    output logic [DATAWIDTH-1:0]       out_3,
    output logic [DATAWIDTH-1:0]       out_4,
    output logic [DATAWIDTH-1:0]       out_5,
    output logic [DATAWIDTH-1:0]       out_6,
    output logic [DATAWIDTH-1:0]       out_7,
    output logic [DATAWIDTH-1:0]       out_8,
    output logic [DATAWIDTH-1:0]       out_9,
    output logic [DATAWIDTH-1:0]       out_10,
    output logic [DATAWIDTH-1:0]       out_11,
    output logic [DATAWIDTH-1:0]       out_12,
    output logic [DATAWIDTH-1:0]       out_13,
    output logic [DATAWIDTH-1:0]       out_14,
    output logic [DATAWIDTH-1:0]       out_15,
    output logic [ROW_W-1:0]           row_idx,
    output logic                       busy,
    output logic                       block_done
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    feeder_state_t              r_state;
    feeder_state_t              w_next_state;
    logic [ROW_W-1:0]           r_load_cnt;
    logic [ROW_W-1:0]           r_stream_cnt;
    logic                       r_enable;
    logic [ROW_W-1:0]           r_row_idx;
    logic [LANES*DATAWIDTH-1:0] r_row;
    logic                       w_wr_en;
    logic                       w_last_load;
    logic                       w_last_stream;
    logic                       w_next_en;
    logic [ROW_W-1:0]           w_next_idx;
    logic [LANES*DATAWIDTH-1:0] w_rd_data;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; abort wins over everything
    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (start)         w_next_state = ST_LOAD;
                ST_LOAD:   if (w_last_load)   w_next_state = ST_STREAM;
                ST_STREAM: if (w_last_stream) w_next_state = ST_DONE;
                ST_DONE:                      w_next_state = ST_IDLE;
                default:                      w_next_state = ST_IDLE;
            endcase
        end
    end

    // State-decoded outputs; ready drops during abort so no row is taken
    always_comb begin
        in_ready   = (r_state == ST_LOAD) && !abort;
        busy       = (r_state != ST_IDLE);
        block_done = (r_state == ST_DONE);
    end

    assign w_wr_en       = in_valid && in_ready;
    assign w_last_load   = w_wr_en && (r_load_cnt == LAST_ROW);
    assign w_last_stream = (r_state == ST_STREAM) && (r_stream_cnt == LAST_ROW);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_load_cnt   <= '0;
            r_stream_cnt <= '0;
        end else if (abort) begin
            r_load_cnt   <= '0;
            r_stream_cnt <= '0;
        end else begin
            if (w_wr_en) begin
                r_load_cnt <= w_last_load ? '0 : r_load_cnt + ROW_W'(1);
            end
            if (r_state == ST_STREAM) begin
                r_stream_cnt <= w_last_stream ? '0 : r_stream_cnt + ROW_W'(1);
            end
        end
    end

    // The output register is loaded one cycle ahead of the row it shows:
    // row 0 on the final load handshake, row k+1 while row k is shown.
    assign w_next_en  = !abort && (w_last_load ||
                        ((r_state == ST_STREAM) && !w_last_stream));
    assign w_next_idx = (r_state == ST_STREAM) ? r_stream_cnt + ROW_W'(1) : '0;

    feeder_row_mem #(
        .DATAWIDTH (DATAWIDTH),
        .LANES     (LANES),
        .ROWS      (ROWS),
        .ROW_W     (ROW_W)
    ) u_row_mem (
        .clock     (clock),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_load_cnt),
        .i_wr_data (in_data),
        .i_rd_addr (w_next_idx),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_enable  <= 1'b0;
            r_row_idx <= '0;
            r_row     <= '0;
        end else begin
            r_enable  <= w_next_en;
            r_row_idx <= w_next_en ? w_next_idx : '0;
            r_row     <= w_next_en ? w_rd_data : '0;
        end
    end

    assign enable_int = r_enable;
    assign row_idx    = r_row_idx;
    assign out_0      = r_row[ 0*DATAWIDTH +: DATAWIDTH];
    assign out_1      = r_row[ 1*DATAWIDTH +: DATAWIDTH];
    assign out_2      = r_row[ 2*DATAWIDTH +: DATAWIDTH];
    assign out_3      = r_row[ 3*DATAWIDTH +: DATAWIDTH];
    assign out_4      = r_row[ 4*DATAWIDTH +: DATAWIDTH];
    assign out_5      = r_row[ 5*DATAWIDTH +: DATAWIDTH];
    assign out_6      = r_row[ 6*DATAWIDTH +: DATAWIDTH];
    assign out_7      = r_row[ 7*DATAWIDTH +: DATAWIDTH];
    assign out_8      = r_row[ 8*DATAWIDTH +: DATAWIDTH];
    assign out_9      = r_row[ 9*DATAWIDTH +: DATAWIDTH];
    assign out_10     = r_row[10*DATAWIDTH +: DATAWIDTH];
    assign out_11     = r_row[11*DATAWIDTH +: DATAWIDTH];
    assign out_12     = r_row[12*DATAWIDTH +: DATAWIDTH];
    assign out_13     = r_row[13*DATAWIDTH +: DATAWIDTH];
    assign out_14     = r_row[14*DATAWIDTH +: DATAWIDTH];
    assign out_15     = r_row[15*DATAWIDTH +: DATAWIDTH];

endmodule

// File: tb/tb_interpolation_feeder.sv
// Self-checking bench for interpolation_feeder. Expected behaviour is
// derived from the block timeline: a block starts the cycle after start in
// IDLE, the Nth row offered with in_valid during loading is row N-1, the
// cycle after the 12th accepted row row 0 is presented, rows follow on
// consecutive cycles, then one block_done cycle, then IDLE.
module tb_interpolation_feeder;

    localparam int DW   = 8;
    localparam int NL   = 16;
    localparam int NR   = 12;
    localparam int RW   = 4;
    localparam int BW   = DW * NL;

    logic          clock;
    logic          reset;
    logic          start;
    logic          abort;
    logic          in_valid;
    logic [BW-1:0] in_data;
    logic          in_ready;
    logic          enable_int;
    logic [DW-1:0] out_0, out_1, out_2, out_3, out_4, out_5, out_6, out_7;
    logic [DW-1:0] out_8, out_9, out_10, out_11, out_12, out_13, out_14, out_15;
    logic [RW-1:0] row_idx;
    logic          busy;
    logic          block_done;
    logic [BW-1:0] w_outs;

    int n_checks = 0;
    int n_pass   = 0;

    logic [BW-1:0] blk [NR];

    typedef struct {
        bit s_start;
        bit s_abort;
        bit s_valid;
        bit exp_busy;
    } idle_vec_t;

    interpolation_feeder dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .enable_int (enable_int),
        .out_0      (out_0),
        .out_1      (out_1),
        .out_2      (out_2),
        .out_3      (out_3),
        .out_4      (out_4),
        .out_5      (out_5),
        .out_6      (out_6),
        .out_7      (out_7),
        .out_8      (out_8),
        .out_9      (out_9),
        .out_10     (out_10),
        .out_11     (out_11),
        .out_12     (out_12),
        .out_13     (out_13),
        .out_14     (out_14),
        .out_15     (out_15),
        .row_idx    (row_idx),
        .busy       (busy),
        .block_done (block_done)
    );

    assign w_outs = {out_15, out_14, out_13, out_12, out_11, out_10, out_9, out_8,
                     out_7, out_6, out_5, out_4, out_3, out_2, out_1, out_0};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [BW-1:0] junk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic fill_block(input bit seq);
        for (int r = 0; r < NR; r++) begin
            if (seq) begin
                for (int i = 0; i < NL; i++) blk[r][i*DW +: DW] = 8'(r * 16 + i);
            end else begin
                blk[r] = junk();
            end
        end
    endtask

    task automatic chk_quiet(input string tag, input logic exp_busy, input logic exp_done);
        chk({tag, " enable_int"}, BW'(enable_int), BW'(0));
        chk({tag, " out_*"},      w_outs,          BW'(0));
        chk({tag, " row_idx"},    BW'(row_idx),    BW'(0));
        chk({tag, " in_ready"},   BW'(in_ready),   BW'(0));
        chk({tag, " busy"},       BW'(busy),       BW'(exp_busy));
        chk({tag, " block_done"}, BW'(block_done), BW'(exp_done));
    endtask

    // Runs one block from an IDLE cycle. gap_mode: 0 in_valid always high,
    // 1 in_valid every other cycle, 2 random. abort_row < 0 means no abort.
    task automatic run_block(input string tag, input int gap_mode, input bit hold_start,
                             input int abort_row);
        int acc;
        int lc;
        bit v;
        start = 1'b1; abort = 1'b0; in_valid = 1'b0; in_data = junk();
        #1;
        chk({tag, " idle busy"}, BW'(busy), BW'(0));
        chk({tag, " idle in_ready"}, BW'(in_ready), BW'(0));
        step();
        acc = 0;
        lc  = 0;
        while (acc < NR) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (lc % 2 == 0);
                default: v = ($urandom_range(0, 1) == 1) || (lc > 60);
            endcase
            in_valid = v;
            in_data  = v ? blk[acc] : junk();
            start    = 1'($urandom_range(0, 1));
            #1;
            chk($sformatf("%s load%0d in_ready", tag, lc), BW'(in_ready), BW'(1));
            chk($sformatf("%s load%0d busy", tag, lc), BW'(busy), BW'(1));
            chk($sformatf("%s load%0d enable_int", tag, lc), BW'(enable_int), BW'(0));
            if (v) acc++;
            lc++;
            step();
        end
        for (int k = 0; k < NR; k++) begin
            start    = hold_start;
            in_valid = 1'($urandom_range(0, 1));
            in_data  = junk();
            abort    = (k == abort_row);
            #1;
            chk($sformatf("%s row%0d enable_int", tag, k), BW'(enable_int), BW'(1));
            chk($sformatf("%s row%0d row_idx", tag, k), BW'(row_idx), BW'(k));
            chk($sformatf("%s row%0d out_*", tag, k), w_outs, blk[k]);
            chk($sformatf("%s row%0d in_ready", tag, k), BW'(in_ready), BW'(0));
            chk($sformatf("%s row%0d block_done", tag, k), BW'(block_done), BW'(0));
            step();
            if (k == abort_row) begin
                abort = 1'b0; start = 1'b0; in_valid = 1'b0;
                #1;
                chk_quiet({tag, " post-abort"}, 1'b0, 1'b0);
                step();
                chk({tag, " post-abort+1 block_done"}, BW'(block_done), BW'(0));
                chk({tag, " post-abort+1 busy"}, BW'(busy), BW'(0));
                return;
            end
        end
        start = hold_start; in_valid = 1'b0;
        #1;
        chk_quiet({tag, " done"}, 1'b1, 1'b1);
        step();
        start = 1'b0;
        #1;
        chk_quiet({tag, " after-done"}, 1'b0, 1'b0);
    endtask

    idle_vec_t vecs [6];

    initial begin
        vecs[0] = '{s_start: 1'b0, s_abort: 1'b0, s_valid: 1'b0, exp_busy: 1'b0};
        vecs[1] = '{s_start: 1'b0, s_abort: 1'b0, s_valid: 1'b1, exp_busy: 1'b0};
        vecs[2] = '{s_start: 1'b1, s_abort: 1'b1, s_valid: 1'b0, exp_busy: 1'b0};
        vecs[3] = '{s_start: 1'b1, s_abort: 1'b1, s_valid: 1'b1, exp_busy: 1'b0};
        vecs[4] = '{s_start: 1'b1, s_abort: 1'b0, s_valid: 1'b0, exp_busy: 1'b1};
        vecs[5] = '{s_start: 1'b1, s_abort: 1'b0, s_valid: 1'b1, exp_busy: 1'b1};

        reset = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
        #1;
        chk_quiet("reset", 1'b0, 1'b0);
        repeat (3) @(posedge clock);
        #3;
        reset = 1'b1;
        step();
        chk_quiet("post-reset", 1'b0, 1'b0);

        // IDLE response table; a vector that enters LOAD is aborted back out
        for (int n = 0; n < 6; n++) begin
            start = vecs[n].s_start; abort = vecs[n].s_abort;
            in_valid = vecs[n].s_valid; in_data = junk();
            #1;
            chk($sformatf("vec%0d idle in_ready", n), BW'(in_ready), BW'(0));
            step();
            start = 1'b0; abort = 1'b0; in_valid = 1'b0;
            #1;
            chk($sformatf("vec%0d busy", n), BW'(busy), BW'(vecs[n].exp_busy));
            chk($sformatf("vec%0d in_ready", n), BW'(in_ready), BW'(vecs[n].exp_busy));
            if (vecs[n].exp_busy) begin
                abort = 1'b1; in_valid = 1'b1;
                #1;
                chk($sformatf("vec%0d abort in_ready", n), BW'(in_ready), BW'(0));
                step();
                abort = 1'b0; in_valid = 1'b0;
                #1;
                chk($sformatf("vec%0d aborted busy", n), BW'(busy), BW'(0));
            end
            step();
        end

        fill_block(1'b1);
        run_block("s1", 0, 1'b0, -1);
        run_block("s2", 1, 1'b0, -1);
        fill_block(1'b0);
        run_block("s3", 0, 1'b1, -1);
        fill_block(1'b0);
        run_block("s4a", 2, 1'b0, 6);
        fill_block(1'b0);
        run_block("s4b", 0, 1'b0, -1);

        // Reset in the middle of a load, then a fresh block of new data
        fill_block(1'b0);
        start = 1'b1; #1; step();
        start = 1'b0;
        for (int r = 0; r < 7; r++) begin
            in_valid = 1'b1; in_data = blk[r];
            step();
        end
        #2;
        reset = 1'b0;
        #1;
        chk_quiet("s5 async reset", 1'b0, 1'b0);
        in_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        chk_quiet("s5 released", 1'b0, 1'b0);
        fill_block(1'b0);
        run_block("s5", 0, 1'b0, -1);

        for (int n = 0; n < 8; n++) begin
            int ar;
            ar = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NR - 1)) : -1;
            fill_block(1'b0);
            run_block($sformatf("rnd%0d", n), int'($urandom_range(0, 2)),
                      1'($urandom_range(0, 1)), ar);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
